// File: rtl/fib_pkg.sv
// Shared types and constants for the iterative Fibonacci sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fib_pkg;

    // Datapath width of the index, both terms and the target.
    localparam int FIB_W = 11;

    // Sequencer states: waiting for a request, stepping, one-cycle completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fib_state_t;

    // Term values after reset, before any request has been accepted.
    localparam logic [FIB_W-1:0] FIB_N_RST = '0;
    localparam logic [FIB_W-1:0] FIB_K_RST = '0;

    // Seed loaded on acceptance: n = F(-1) = 1, k = F(0) = 0.
    localparam logic [FIB_W-1:0] FIB_N0 = FIB_W'(1);
    localparam logic [FIB_W-1:0] FIB_K0 = '0;

endpackage : fib_pkg

// File: rtl/fib_step.sv
// One step of the (n, k) Fibonacci recurrence: k' = k + n, n' = k.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to register the result.
module fib_step #(
    parameter int W = fib_pkg::FIB_W
) (
    input  logic [W-1:0] n,
    input  logic [W-1:0] k,
    output logic [W-1:0] k_next,
    output logic [W-1:0] n_next,
    output logic         carry
);

    logic [W:0] sum;

    // Widen by one bit so the carry out of the top bit is kept for the overflow flag.
    always_comb begin
        sum    = {1'b0, k} + {1'b0, n};
        k_next = sum[W-1:0];
        n_next = k;
        carry  = sum[W];
    end

endmodule : fib_step

// File: rtl/fib_seq_ctrl.sv
// Sequencer for the iterative Fibonacci datapath: latches a target index and steps F(i) until i == target.
// Latency: done pulses after target+1 rising edges from acceptance (plus one per stalled cycle).
// Backpressure: selector=0 stalls RUN indefinitely; start is only accepted in IDLE and never queued.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int W = FIB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] target,
    input  logic         selector,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [W-1:0] i,
    output logic [W-1:0] n,
    output logic [W-1:0] k
);

    localparam logic [W-1:0] ONE = W'(1);

    fib_state_t   state_q, state_nxt;
    logic [W-1:0] i_q, i_nxt;
    logic [W-1:0] n_q, n_nxt;
    logic [W-1:0] k_q, k_nxt;
    logic [W-1:0] tgt_q, tgt_nxt;
    logic         ovf_q, ovf_nxt;

    logic [W-1:0] step_k;
    logic [W-1:0] step_n;
    logic         step_carry;
    logic [W-1:0] i_inc;

    fib_step #(.W(W)) u_step (
        .n      (n_q),
        .k      (k_q),
        .k_next (step_k),
        .n_next (step_n),
        .carry  (step_carry)
    );

    assign i_inc = i_q + ONE;

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and datapath-next logic; everything holds unless a state below says otherwise.
    always_comb begin
        state_nxt = state_q;
        i_nxt     = i_q;
        n_nxt     = n_q;
        k_nxt     = k_q;
        ovf_nxt   = ovf_q;
        tgt_nxt   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                // Previous result stays visible until a new request arrives.
                if (start) begin
                    tgt_nxt   = target;
                    n_nxt     = W'(FIB_N0);
                    k_nxt     = W'(FIB_K0);
                    i_nxt     = '0;
                    ovf_nxt   = 1'b0;
                    // F(0) is already in k after seeding, so target 0 finishes immediately.
                    state_nxt = (target == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (selector) begin
                    k_nxt   = step_k;
                    n_nxt   = step_n;
                    i_nxt   = i_inc;
                    ovf_nxt = ovf_q | step_carry;
                    // Finish on the step that reaches the target so i never passes it.
                    if (i_inc == tgt_q) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: index, terms, latched target and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q   <= '0;
            n_q   <= W'(FIB_N_RST);
            k_q   <= W'(FIB_K_RST);
            tgt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            i_q   <= i_nxt;
            n_q   <= n_nxt;
            k_q   <= k_nxt;
            tgt_q <= tgt_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    // All outputs come straight from registers.
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign ovf  = ovf_q;
    assign i    = i_q;
    assign n    = n_q;
    assign k    = k_q;

endmodule : fib_seq_ctrl

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl with a result scoreboard.
// Latency: checks done timing against target+1 edges (or 2*target with alternating stalls).
// Backpressure: exercises selector stalls, ignored mid-run starts and held start.
module tb_fib_seq_ctrl;

    localparam int W = 11;

    typedef struct packed {
        logic [W-1:0] k;
        logic [W-1:0] n;
        logic [W-1:0] i;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] target;
    logic         selector;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [W-1:0] i;
    logic [W-1:0] n;
    logic [W-1:0] k;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t sb[$];

    fib_seq_ctrl #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .target   (target),
        .selector (selector),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .i        (i),
        .n        (n),
        .k        (k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference recurrence with explicit 12-bit sum for the carry.
    function automatic exp_t fib_model(input int t);
        exp_t       e;
        logic [W:0] sum;
        e.n   = W'(1);
        e.k   = '0;
        e.i   = t[W-1:0];
        e.ovf = 1'b0;
        for (int s = 0; s < t; s++) begin
            sum   = {1'b0, e.k} + {1'b0, e.n};
            e.ovf = e.ovf | sum[W];
            e.n   = e.k;
            e.k   = sum[W-1:0];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_k", 32'(k), 32'(e.k));
                chk("res_n", 32'(n), 32'(e.n));
                chk("res_i", 32'(i), 32'(e.i));
                chk("res_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // One request from IDLE; checks latency, busy length, ovf clearing and the return to IDLE.
    task automatic run_one(input int t, input bit alt, input bit inject, input int exp_lat, input string tag);
        int edges    = 0;
        int busy_cnt = 0;
        bit seen     = 0;
        target   = t[W-1:0];
        start    = 1'b1;
        selector = 1'b1;
        sb.push_back(fib_model(t));
        while (!seen && edges < 6000) begin
            tick();
            edges++;
            if (edges == 1) begin
                start = 1'b0;
                chk({tag, "_ovf_clr"}, 32'(ovf), 0);
                target = ~target;
            end
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
            if (inject) start = (edges == 4 || edges == 9);
            if (alt) selector = ((edges + 1) % 2 == 0);
        end
        start    = 1'b0;
        selector = 1'b1;
        chk({tag, "_lat"}, seen ? edges : -1, exp_lat);
        chk({tag, "_busy"}, busy_cnt, exp_lat - 1);
        tick();
        chk({tag, "_idle_done"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int   edges;
        int   prev;
        int   ndone;
        exp_t dropped;

        rst      = 1'b1;
        start    = 1'b0;
        target   = '0;
        selector = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_i", 32'(i), 0);
        chk("rst_n", 32'(n), 0);
        chk("rst_k", 32'(k), 0);
        chk("rst_ovf", 32'(ovf), 0);

        // Plain run, target 10.
        run_one(10, 1'b0, 1'b0, 11, "t10");
        chk("t10_k_hold", 32'(k), 55);
        chk("t10_n_hold", 32'(n), 34);
        chk("t10_i_hold", 32'(i), 10);

        // Largest index without overflow, then the first one with it.
        run_one(17, 1'b0, 1'b0, 18, "t17");
        chk("t17_k", 32'(k), 1597);
        chk("t17_ovf", 32'(ovf), 0);
        run_one(18, 1'b0, 1'b0, 19, "t18");
        chk("t18_k", 32'(k), 536);
        chk("t18_n", 32'(n), 1597);
        chk("t18_ovf", 32'(ovf), 1);

        // Zero target finishes on the cycle after acceptance; also clears the earlier ovf.
        run_one(0, 1'b0, 1'b0, 1, "t0");
        chk("t0_k", 32'(k), 0);
        chk("t0_n", 32'(n), 1);

        // Alternating stalls with ignored start pulses mid-run.
        run_one(10, 1'b1, 1'b1, 20, "alt10");
        chk("alt10_k", 32'(k), 55);

        // Reset mid-run at i == 7.
        target   = 11'd20;
        selector = 1'b1;
        start    = 1'b1;
        sb.push_back(fib_model(20));
        edges = 0;
        while (i != 11'd7 && edges < 100) begin
            tick();
            edges++;
            start = 1'b0;
        end
        chk("mid_reach_i7", 32'(i), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dropped = sb.pop_back();
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_i", 32'(i), 0);
        chk("mid_n", 32'(n), 0);
        chk("mid_k", 32'(k), 0);
        chk("mid_ovf", 32'(ovf), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_no_done", 32'(done), 0);
        end
        run_one(5, 1'b0, 1'b0, 6, "t5");
        chk("t5_k", 32'(k), 5);
        chk("t5_n", 32'(n), 3);

        // Start held high: back-to-back runs of target 3.
        target   = 11'd3;
        selector = 1'b1;
        for (int r = 0; r < 3; r++) sb.push_back(fib_model(3));
        start = 1'b1;
        edges = 0;
        prev  = 0;
        ndone = 0;
        while (ndone < 3 && edges < 200) begin
            tick();
            edges++;
            if (done) begin
                if (ndone == 0) chk("hold_first", edges, 4);
                else chk("hold_gap", edges - prev, 5);
                chk("hold_k", 32'(k), 2);
                prev = edges;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        chk("hold_count", ndone, 3);
        tick();
        chk("hold_idle_busy", 32'(busy), 0);
        tick();
        chk("hold_no_accept", 32'(busy), 0);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_fib_seq_ctrl

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Sequencing controller for the 11-bit iterative Fibonacci datapath in the fib_21 arithmetic case.
- Accepts a start request with a target index and steps the (n, k) recurrence once per enabled cycle, using selector as the per-cycle advance/stall control.
- Reports done, the iteration count i, and a sticky overflow flag.
- Sits between a stimulus source (testbench or upper sequencer) and the fib datapath; owns all sequencing state.

Parameters:
- W, 11, datapath width of i, n, k and target; all arithmetic is modulo 2^W.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request a new computation; sampled only in IDLE.
- target, input, W, index to compute; latched when start is accepted.
- selector, input, 1, advance enable in RUN: 1 = step, 0 = stall (hold all state).
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle pulse in DONE.
- ovf, output, 1, sticky flag: some step produced a carry out of bit W-1.
- i, output, W, current iteration index.
- n, output, W, previous term F(i-1).
- k, output, W, current term F(i).

Behaviour:
- Reset (rst=1 at a rising edge, from any state, including mid-RUN): state=IDLE, i=0, n=0, k=0, ovf=0, busy=0, done=0, latched target=0. Reset has priority over every other input.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE). Outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - start=0: hold i, n, k and ovf, which keep showing the previous result.
  - start=1: latch target; load n=1, k=0, i=0 (F(-1)=1, F(0)=0); clear ovf.
  - Next state is DONE if target==0, else RUN.
- RUN, selector=0: hold everything; stalls are unbounded.
- RUN, selector=1 (one step):
  - k <= k+n truncated to W bits; n <= old k; i <= i+1.
  - ovf <= ovf | carry-out of k+n.
  - If i+1 == latched target, go to DONE on the same edge; else stay in RUN.
- DONE: lasts exactly one cycle, then IDLE. Results hold.
- start is ignored in RUN and DONE; no queuing. A start held high through DONE is accepted on the first IDLE cycle.
- Changes to target after acceptance have no effect.
- Latency with selector held at 1: done is high in the cycle after T+1 rising edges, counting the accepting edge. T=0 gives done one cycle after acceptance. Each stalled cycle adds one.
- Results at done: k = F(T) mod 2^W, n = F(T-1) mod 2^W, i = T.
- Wrap-around: i never exceeds T, so there is no index wrap. T=2047 is legal and takes 2047 steps.

Decomposition:
- Package fib_pkg holds:
  - localparam FIB_W = 11;
  - state enum {ST_IDLE, ST_RUN, ST_DONE};
  - reset constants for n and k;
  - seed constants FIB_N0 = 1, FIB_K0 = 0.
- One sub-module, fib_step: combinational datapath.
  - Inputs: n, k.
  - Outputs: k_next, n_next, carry.
- fib_seq_ctrl owns the FSM, the i counter, the target latch and the ovf register.

Test Plan:
- rst=1 for 2 cycles, then start=1, target=10, selector=1 held -> done pulses 11 edges after acceptance; k=55, n=34, i=10, ovf=0; busy high for 10 cycles.
- start, target=17, selector=1 -> k=1597, n=987, i=17, ovf=0. Then start, target=18 -> k=536 (2584 mod 2048), n=1597, ovf=1; the next start clears ovf.
- target=0, start -> done on the next cycle; k=0, n=1, i=0; busy never asserts.
- target=10, selector alternating 1/0 starting with 1 -> done after 20 edges; same result k=55. Start pulses injected mid-RUN are ignored and the result is unchanged.
- target=20, rst=1 asserted when i=7 -> next cycle: state IDLE, i=n=k=0, ovf=0, busy=0, no done pulse. A fresh start with target=5 then gives k=5, n=3.
- start held high continuously, target=3 -> back-to-back runs; each done is followed by IDLE acceptance on the next cycle; k=2 after every done.
